// File: rtl/move_pkg.sv
// Shared definitions for the MOVE step/direction interface: default widths,
// the receiver qualification FSM states and the system clock rate.
package move_pkg;

   localparam int CLK_HZ           = 50_000_000;
   localparam int POS_W_DEF        = 24;
   localparam int PER_W_DEF        = 20;
   // 10 ms of step silence before the axis is reported idle
   localparam int IDLE_TIMEOUT_DEF = CLK_HZ / 100;

   typedef enum logic [1:0] {
      LOW  = 2'd0,
      QUAL = 2'd1,
      HIGH = 2'd2
   } step_state_t;

endpackage

// File: rtl/move_sync2.sv
// Two-flop synchronizer bringing an asynchronous line into the clk domain.
module move_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbour; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/move_step_rx.sv
// Step/direction receiver: qualifies step pulses, keeps a saturating signed
// position, measures step period, and reports moving status and sticky faults.
module move_step_rx
   import move_pkg::*;
#(
   parameter int POS_W        = POS_W_DEF,
   parameter int PER_W        = PER_W_DEF,
   parameter int MIN_HIGH     = 5,
   parameter int DIR_SETUP    = 2,
   parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    step_in,
   input  logic                    dir_in,
   input  logic                    clr_pos,
   input  logic                    fault_clr,
   output logic signed [POS_W-1:0] position,
   output logic                    step_strobe,
   output logic                    dir_out,
   output logic                    moving,
   output logic [PER_W-1:0]        period,
   output logic                    period_valid,
   output logic                    fault_glitch,
   output logic                    fault_dir,
   output logic                    fault_limit
);

   localparam int DS_W   = $clog2(DIR_SETUP + 2);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   localparam logic [7:0]        MIN_HIGH_C  = 8'(MIN_HIGH);
   localparam logic [DS_W-1:0]   DIR_SETUP_C = DS_W'(DIR_SETUP);
   localparam logic [IDLE_W-1:0] IDLE_LAST_C = IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [POS_W-1:0]  POS_MAX     = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic [POS_W-1:0]  POS_MIN     = {1'b1, {(POS_W-1){1'b0}}};

   logic              step_s;
   logic              dir_s;
   logic              dir_q;
   logic              dir_chg;
   logic              dir_stable;
   logic [DS_W-1:0]   dir_cnt;
   logic [1:0]        fill_cnt;
   logic              armed;

   step_state_t       state;
   step_state_t       state_nx;
   logic [7:0]        hi_cnt;
   logic [7:0]        hi_cnt_nx;
   logic              dir_lat;
   logic              dir_lat_nx;
   logic              setup_ok;
   logic              setup_ok_nx;

   logic              glitch_ev;
   logic              dir_ev;
   logic              limit_ev;
   logic              at_limit;

   logic [PER_W-1:0]  per_cnt;
   logic [IDLE_W-1:0] idle_cnt;

   move_sync2 u_sync_step (
      .clk (clk),
      .rst (rst),
      .d   (step_in),
      .q   (step_s)
   );

   move_sync2 u_sync_dir (
      .clk (clk),
      .rst (rst),
      .d   (dir_in),
      .q   (dir_s)
   );

   assign dir_chg    = dir_s ^ dir_q;
   assign dir_stable = !dir_chg && (dir_cnt >= DIR_SETUP_C);

   // The synchronizer reloads from zero after reset, so a line already high
   // must first be seen low once the pipeline has refilled before it can count.
   always_ff @(posedge clk) begin
      if (rst) begin
         dir_q    <= 1'b0;
         dir_cnt  <= '0;
         fill_cnt <= 2'd0;
         armed    <= 1'b0;
      end else begin
         dir_q <= dir_s;
         if (dir_chg)
            dir_cnt <= DS_W'(1);
         else if (dir_cnt < DIR_SETUP_C)
            dir_cnt <= dir_cnt + DS_W'(1);
         if (fill_cnt != 2'd2)
            fill_cnt <= fill_cnt + 2'd1;
         if (fill_cnt == 2'd2 && !step_s)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOW;
         hi_cnt   <= 8'd0;
         dir_lat  <= 1'b0;
         setup_ok <= 1'b0;
      end else begin
         state    <= state_nx;
         hi_cnt   <= hi_cnt_nx;
         dir_lat  <= dir_lat_nx;
         setup_ok <= setup_ok_nx;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      hi_cnt_nx   = hi_cnt;
      dir_lat_nx  = dir_lat;
      setup_ok_nx = setup_ok;
      case (state)
         LOW: begin
            if (step_s && armed) begin
               state_nx    = QUAL;
               hi_cnt_nx   = 8'd1;
               dir_lat_nx  = dir_s;
               setup_ok_nx = dir_stable;
            end
         end
         QUAL: begin
            if (hi_cnt == MIN_HIGH_C)
               state_nx = step_s ? HIGH : LOW;
            else if (!step_s)
               state_nx = LOW;
            else
               hi_cnt_nx = hi_cnt + 8'd1;
         end
         HIGH: begin
            if (!step_s)
               state_nx = LOW;
         end
         default: state_nx = LOW;
      endcase
   end

   always_comb begin
      step_strobe = 1'b0;
      glitch_ev   = 1'b0;
      dir_ev      = 1'b0;
      case (state)
         LOW:  dir_ev = step_s && armed && !dir_stable;
         QUAL: begin
            step_strobe = (hi_cnt == MIN_HIGH_C);
            glitch_ev   = (hi_cnt != MIN_HIGH_C) && !step_s;
            dir_ev      = dir_chg;
         end
         HIGH: dir_ev = dir_chg;
         default: ;
      endcase
   end

   assign at_limit = dir_lat ? (position == POS_MAX) : (position == POS_MIN);
   assign limit_ev = step_strobe && !clr_pos && at_limit;

   // A clear in the strobe cycle drops the step; direction still follows it.
   always_ff @(posedge clk) begin
      if (rst) begin
         position <= '0;
         dir_out  <= 1'b0;
      end else begin
         if (step_strobe)
            dir_out <= dir_lat;
         if (clr_pos)
            position <= '0;
         else if (step_strobe && !at_limit)
            position <= dir_lat ? position + POS_W'(1) : position - POS_W'(1);
      end
   end

   // On idle timeout the period counter restarts but the last period is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_cnt      <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         moving       <= 1'b0;
         idle_cnt     <= '0;
      end else if (step_strobe) begin
         period       <= per_cnt;
         per_cnt      <= PER_W'(1);
         period_valid <= moving;
         moving       <= 1'b1;
         idle_cnt     <= IDLE_W'(1);
      end else begin
         if (per_cnt != '1)
            per_cnt <= per_cnt + PER_W'(1);
         if (moving) begin
            if (idle_cnt == IDLE_LAST_C) begin
               moving       <= 1'b0;
               period_valid <= 1'b0;
               per_cnt      <= '0;
               idle_cnt     <= '0;
            end else begin
               idle_cnt <= idle_cnt + IDLE_W'(1);
            end
         end
      end
   end

   // A new event in the same cycle as fault_clr keeps the fault set.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_glitch <= 1'b0;
         fault_dir    <= 1'b0;
         fault_limit  <= 1'b0;
      end else begin
         fault_glitch <= (fault_glitch && !fault_clr) || glitch_ev;
         fault_dir    <= (fault_dir    && !fault_clr) || dir_ev;
         fault_limit  <= (fault_limit  && !fault_clr) || limit_ev;
      end
   end

endmodule

// File: doc/move_step_rx.md
Name: move_step_rx

Overview:
Receiver end of the MOVE step/direction interface. Accepts the step and direction lines driven by the motion generator, synchronizes and qualifies them, and keeps a signed position count. Also measures the step period and reports moving/idle status and sticky faults. Sits on the drive side of the MOVE block and provides position feedback to supervisory logic.

Parameters:
POS_W, 24, width of the signed position count
PER_W, 20, width of the step period measurement (clocks)
MIN_HIGH, 5, step must be high this many consecutive synced clocks to count (range 2..255)
DIR_SETUP, 2, clocks dir must be stable before step rise
IDLE_TIMEOUT, 500000, clocks without a qualified step before moving drops (10 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous reset, active-high
step_in  in  1  async step line; rising edge = one step
dir_in  in  1  async direction line; 1 = +, 0 = -
clr_pos  in  1  one-clock pulse; zero the position
fault_clr  in  1  one-clock pulse; clear sticky faults
position  out  POS_W  signed step count
step_strobe  out  1  one-clock pulse per qualified step
dir_out  out  1  direction latched with the last qualified step
moving  out  1  a qualified step occurred within IDLE_TIMEOUT
period  out  PER_W  clocks between the last two qualified steps
period_valid  out  1  period holds a real measurement
fault_glitch  out  1  sticky; step high pulse shorter than MIN_HIGH
fault_dir  out  1  sticky; dir changed inside the DIR_SETUP window or while step was high
fault_limit  out  1  sticky; step requested at a position extreme

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst); polarity and synchronicity are fixed.
- Reset values: position=0, step_strobe=0, dir_out=0, moving=0, period=0, period_valid=0, all faults=0, FSM=LOW, sync flops=0, dir stable counter=0.
- Reset mid-step discards the pulse in progress. The first count after reset needs a fresh rising edge.
- Synchronization: two flops on each of step_in and dir_in. All logic below uses the synced copies (step_s, dir_s).
- dir stable counter: counts clocks since dir_s last changed, saturating at DIR_SETUP.
- FSM, states LOW / QUAL / HIGH:
  - LOW: on step_s=1, go to QUAL with hi_cnt=1. Latch the direction and a setup-OK flag (stable counter >= DIR_SETUP).
  - QUAL: while step_s=1, increment hi_cnt. When hi_cnt reaches MIN_HIGH, assert step_strobe for that single clock and go to HIGH. If step_s=0 first, set fault_glitch, count nothing, and return to LOW.
  - HIGH: wait for step_s=0, then go to LOW. No further counts occur in this state.
- dir_s toggling in QUAL or HIGH sets fault_dir. The direction latched at the rise is still used.
- A rise with setup-OK=0 still counts but sets fault_dir.
- Latency: step_in held high from clock edge N produces step_strobe in cycle N+MIN_HIGH+1. position and dir_out update on the following edge.
- Position arithmetic: +1 if the latched direction is 1, -1 otherwise. Saturates at the signed extremes (+2^(POS_W-1)-1 and -2^(POS_W-1)). A step at an extreme leaves position unchanged and sets fault_limit. No wrap-around.
- clr_pos: position becomes 0. If clr_pos and step_strobe occur in the same cycle, clr_pos wins and the step is dropped; dir_out and period still update.
- Period counter: increments every clock and saturates at all-ones.
  - On step_strobe: period <= counter, counter <= 1.
  - period_valid=1 from the second strobe onward while moving.
- Idle counter: reloaded on step_strobe. When it reaches IDLE_TIMEOUT, moving=0, period_valid=0, the period counter resets, and period holds its last value. moving=1 in the cycle after any step_strobe.
- Faults are sticky until fault_clr. If fault_clr coincides with a new fault event, the fault stays set.

Decomposition:
- Shared package move_pkg: POS_W/PER_W defaults, FSM state enum (LOW, QUAL, HIGH), and constant CLK_HZ=50_000_000 for deriving IDLE_TIMEOUT.
- One natural sub-module: move_sync2, a 2-flop synchronizer, instantiated for step_in and dir_in.
- FSM, counters and fault logic stay in move_step_rx.

Test Plan:
- Reset: pulse rst for 3 clocks during a step high -> all outputs 0. The held-high step does not count; the next full pulse gives position=1.
- 10 pulses, dir=1, high 10 clocks, period 200 clocks -> position=10, step_strobe 10 times, first strobe 6 clocks after the rise, period=200, period_valid=1 after the 2nd pulse.
- 4 pulses dir=0, then 3-clock pulse, then dir toggle 1 clock before a rise -> position=-4, fault_glitch=1, fault_dir=1. Pulse 6 counts as -1 (position=-5). fault_clr -> both 0.
- clr_pos in the same cycle as step_strobe at position=7 -> position=0 next clock, dir_out updated.
- POS_W=4 build: 8 up-steps -> position stays 7 and fault_limit=1 after the 8th. Then 16 down-steps -> position=-8.
- Stop stepping for IDLE_TIMEOUT (reduced to 1000) -> moving falls exactly 1000 clocks after the last strobe, period_valid=0, period holds its last value.
